// File: rtl/fm_pkg.sv
// Shared types and defaults for the tick frequency meter and its input conditioning.
package fm_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } fm_state_e;

    localparam int unsigned FM_GATE_LONG_DEF  = 50000000;
    localparam int unsigned FM_GATE_SHORT_DEF = 500000;
    localparam int unsigned FM_CNT_W_DEF      = 32;

    function automatic logic [31:0] fm_sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sig_edge_sync.sv
// Two-flop synchroniser plus edge flop; rising-edge pulse is held off for three
// cycles after reset so a level already high at release is not seen as an edge.
module sig_edge_sync
    import fm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_edge
);

    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic [1:0] r_prime;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_prime <= 2'd0;
        end else begin
            r_s1 <= i_sig;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (r_prime != 2'd3) begin
                r_prime <= r_prime + 2'd1;
            end
        end
    end

    assign o_edge = r_s2 & ~r_s3 & (r_prime == 2'd3);

endmodule

// File: rtl/tick_freq_meter.sv
// Gate-window frequency meter: counts sig_in rising edges over GATE_LONG/GATE_SHORT clk cycles.
// Optional period measurement enabled by defining FREQ_METER_PERIOD_EN.
module tick_freq_meter
    import fm_pkg::*;
#(
    parameter int unsigned CNT_W      = FM_CNT_W_DEF,
    parameter int unsigned GATE_LONG  = FM_GATE_LONG_DEF,
    parameter int unsigned GATE_SHORT = FM_GATE_SHORT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             select,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy,
    output logic             gate_tick
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [31:0]      period_out,
    output logic             period_valid
`endif
);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_GATE = GATE;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && !(&v)) ? v + CNT_W'(1) : v;
    endfunction

    logic [0:0]       r_state;
    logic [31:0]      r_gate_len;
    logic [31:0]      r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_ovf;
    logic             w_edge;
    logic             w_last;
    logic             w_full;
    logic             w_start;

    sig_edge_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (sig_in),
        .o_edge (w_edge)
    );

    assign w_full    = &r_edge_cnt;
    assign w_last    = (r_state == S_GATE) && (r_gate_cnt == r_gate_len - 32'd1);
    assign w_start   = en && ((r_state == S_IDLE) || w_last);
    assign busy      = (r_state == S_GATE);
    assign gate_tick = w_last;

    // Control and reported results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            count_out   <= '0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (r_state == S_IDLE) begin
                if (en) begin
                    r_state <= S_GATE;
                end
            end else begin
                if (w_last) begin
                    count_out   <= sat_inc(r_edge_cnt, w_edge);
                    overflow    <= r_ovf | (w_edge & w_full);
                    count_valid <= 1'b1;
                end
                if (!en) begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    // Window counters; a restart on the last cycle lets the next window begin without a gap
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_gate_len <= select ? GATE_SHORT : GATE_LONG;
            r_gate_cnt <= 32'd0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (r_state == S_GATE) begin
            r_gate_cnt <= r_gate_cnt + 32'd1;
            if (w_edge) begin
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_edge_cnt <= r_edge_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    logic [31:0] r_per_cnt;
    logic        r_per_armed;

    // The first edge after en rises only arms the counter; later edges report the gap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_per_cnt    <= 32'd0;
            r_per_armed  <= 1'b0;
            period_out   <= 32'd0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!en) begin
                r_per_cnt   <= 32'd0;
                r_per_armed <= 1'b0;
            end else if (w_edge) begin
                r_per_cnt   <= 32'd1;
                r_per_armed <= 1'b1;
                if (r_per_armed) begin
                    period_out   <= r_per_cnt;
                    period_valid <= 1'b1;
                end
            end else if (r_per_armed) begin
                r_per_cnt <= fm_sat_inc32(r_per_cnt);
            end
        end
    end
`endif

endmodule
